// File: rtl/mem_bus_arbiter.sv
// Shares one external memory bus between the IF fetch port and the MEM load/store port.
// Non-preemptive request/ack FSM with registered bus outputs, ready pulses and a wait-state timeout.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err,
  output logic        stallreq_if,
  output logic        stallreq_mem
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          kill;
  logic          issue_if, issue_mem, done_ack, done_tmo;

  always_comb begin
    state_nxt = state;
    issue_if  = 1'b0;
    issue_mem = 1'b0;
    done_ack  = 1'b0;
    done_tmo  = 1'b0;
    case (state)
      IDLE: begin
        // A port whose ready is pulsing right now is retiring, not requesting again.
        if (mem_req && !mem_ready) begin
          state_nxt = BUS_MEM;
          issue_mem = 1'b1;
        end else if (if_req && !if_ready) begin
          state_nxt = BUS_IF;
          issue_if  = 1'b1;
        end
      end
      BUS_IF, BUS_MEM: begin
        if (bus_ack) begin
          state_nxt = IDLE;
          done_ack  = 1'b1;
        end else if (wait_cnt == CNT_LAST) begin
          state_nxt = IDLE;
          done_tmo  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_cyc   <= 1'b0;
      bus_stb   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      bus_err   <= 1'b0;
      wait_cnt  <= '0;
      kill      <= 1'b0;
    end else begin
      state     <= state_nxt;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      bus_err   <= 1'b0;

      if (issue_mem) begin
        bus_cyc   <= 1'b1;
        bus_stb   <= 1'b1;
        bus_we    <= mem_we;
        bus_sel   <= mem_sel;
        bus_addr  <= mem_addr;
        bus_wdata <= mem_wdata;
        wait_cnt  <= '0;
      end else if (issue_if) begin
        bus_cyc   <= 1'b1;
        bus_stb   <= 1'b1;
        bus_we    <= 1'b0;
        bus_sel   <= 4'hF;
        bus_addr  <= if_addr;
        bus_wdata <= '0;
        wait_cnt  <= '0;
      end else if (state != IDLE && !bus_ack) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (state == BUS_IF && flush) kill <= 1'b1;

      if (done_ack || done_tmo) begin
        bus_cyc <= 1'b0;
        bus_stb <= 1'b0;
        bus_err <= done_tmo;
        kill    <= 1'b0;
        if (state == BUS_MEM) begin
          mem_ready <= 1'b1;
          if (done_tmo)     mem_rdata <= '0;
          else if (!bus_we) mem_rdata <= bus_rdata;
        end else if (!(kill || flush)) begin
          // A flush landing in the completing cycle still kills delivery.
          if_ready <= 1'b1;
          if_rdata <= done_tmo ? '0 : bus_rdata;
        end
      end
    end
  end

  assign stallreq_if  = !rst && if_req  && !if_ready;
  assign stallreq_mem = !rst && mem_req && !mem_ready;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs driven and outputs checked on the falling edge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        if_req;
  logic [31:0] if_addr, if_rdata;
  logic        if_ready;
  logic        mem_req, mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        bus_cyc, bus_stb, bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack, bus_err;
  logic        stallreq_if, stallreq_mem;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .bus_err(bus_err),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
  );

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; if_req = 1'b1; if_addr = '0;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({stallreq_if, stallreq_mem} !== 2'b00) begin
      bad++; $display("FAIL reset_stallreq: got %b want 00", {stallreq_if, stallreq_mem});
    end
    total++;
    if ({bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, bus_wdata, if_ready, mem_ready,
         if_rdata, mem_rdata, bus_err} !== '0) begin
      bad++; $display("FAIL reset_outputs: got cyc=%b stb=%b addr=%h rdy=%b%b err=%b want all zero",
                      bus_cyc, bus_stb, bus_addr, if_ready, mem_ready, bus_err);
    end
    if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    total++;
    if (stallreq_if !== 1'b1) begin bad++; $display("FAIL fetch_stall_N: got %b want 1", stallreq_if); end
    @(negedge clk);
    total++;
    if ({bus_stb, bus_cyc, bus_we, bus_sel, bus_addr, bus_wdata} !== {3'b110, 4'hF, 32'h100, 32'h0}) begin
      bad++; $display("FAIL fetch_bus_N1: got stb=%b we=%b sel=%h addr=%h want stb=1 we=0 sel=f addr=100",
                      bus_stb, bus_we, bus_sel, bus_addr);
    end
    total++;
    if (stallreq_if !== 1'b1) begin bad++; $display("FAIL fetch_stall_N1: got %b want 1", stallreq_if); end
    bus_ack = 1'b1; bus_rdata = 32'h00500093;
    @(negedge clk);
    total++;
    if ({if_ready, if_rdata, bus_stb, stallreq_if} !== {1'b1, 32'h00500093, 1'b0, 1'b0}) begin
      bad++; $display("FAIL fetch_ready_N2: got rdy=%b rdata=%h stb=%b stall=%b want 1 00500093 0 0",
                      if_ready, if_rdata, bus_stb, stallreq_if);
    end
    bus_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
    total++;
    if ({if_ready, bus_stb} !== 2'b00) begin
      bad++; $display("FAIL fetch_pulse_width: got rdy=%b stb=%b want 0 0", if_ready, bus_stb);
    end
  endtask

  task automatic test_contention();
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h104;
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h1000; mem_wdata = 32'h0;
    #1;
    total++;
    if ({stallreq_if, stallreq_mem} !== 2'b11) begin
      bad++; $display("FAIL cont_stall_N: got %b want 11", {stallreq_if, stallreq_mem});
    end
    @(negedge clk);
    total++;
    if ({bus_stb, bus_addr} !== {1'b1, 32'h1000}) begin
      bad++; $display("FAIL cont_mem_first: got stb=%b addr=%h want 1 00001000", bus_stb, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 32'h11112222;
    @(negedge clk);
    total++;
    if ({mem_ready, mem_rdata, if_ready, bus_stb, stallreq_if} !== {1'b1, 32'h11112222, 3'b001}) begin
      bad++; $display("FAIL cont_mem_ready_N2: got mrdy=%b mrdata=%h irdy=%b stb=%b stall_if=%b want 1 11112222 0 0 1",
                      mem_ready, mem_rdata, if_ready, bus_stb, stallreq_if);
    end
    bus_ack = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    total++;
    if ({bus_stb, bus_addr, mem_ready, stallreq_if} !== {1'b1, 32'h104, 2'b01}) begin
      bad++; $display("FAIL cont_if_stb_N3: got stb=%b addr=%h mrdy=%b stall_if=%b want 1 00000104 0 1",
                      bus_stb, bus_addr, mem_ready, stallreq_if);
    end
    bus_ack = 1'b1; bus_rdata = 32'h33334444;
    @(negedge clk);
    total++;
    if ({if_ready, if_rdata, mem_ready} !== {1'b1, 32'h33334444, 1'b0}) begin
      bad++; $display("FAIL cont_if_ready_N4: got rdy=%b rdata=%h mrdy=%b want 1 33334444 0",
                      if_ready, if_rdata, mem_ready);
    end
    bus_ack = 1'b0; if_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({bus_stb, if_ready, mem_ready} !== 3'b000) begin
        bad++; $display("FAIL cont_no_dup: got stb=%b irdy=%b mrdy=%b want 000", bus_stb, if_ready, mem_ready);
      end
    end
  endtask

  task automatic test_store_wait();
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, bus_wdata, mem_ready}
          !== {3'b111, 4'b0011, 32'h2000, 32'hDEADBEEF, 1'b0}) begin
        bad++; $display("FAIL store_hold_%0d: got stb=%b we=%b sel=%b addr=%h wdata=%h rdy=%b want 1 1 0011 00002000 deadbeef 0",
                        i, bus_stb, bus_we, bus_sel, bus_addr, bus_wdata, mem_ready);
      end
      if (i == 2) begin bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D; end
    end
    @(negedge clk);
    total++;
    if ({mem_ready, mem_rdata, bus_stb, bus_err} !== {1'b1, 32'h11112222, 2'b00}) begin
      bad++; $display("FAIL store_ready: got rdy=%b rdata=%h stb=%b err=%b want 1 11112222 0 0",
                      mem_ready, mem_rdata, bus_stb, bus_err);
    end
    bus_ack = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h3000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({bus_stb, mem_ready, bus_err} !== 3'b100) begin
        bad++; $display("FAIL tmo_stb_%0d: got stb=%b rdy=%b err=%b want 100", i, bus_stb, mem_ready, bus_err);
      end
    end
    @(negedge clk);
    total++;
    if ({bus_stb, bus_cyc, mem_ready, mem_rdata, bus_err} !== {3'b001, 32'h0, 1'b1}) begin
      bad++; $display("FAIL tmo_term: got stb=%b cyc=%b rdy=%b rdata=%h err=%b want 0 0 1 00000000 1",
                      bus_stb, bus_cyc, mem_ready, mem_rdata, bus_err);
    end
    mem_req = 1'b0;
    if_req = 1'b1; if_addr = 32'h108;
    @(negedge clk);
    total++;
    if ({mem_ready, bus_err} !== 2'b00) begin
      bad++; $display("FAIL tmo_err_width: got rdy=%b err=%b want 00", mem_ready, bus_err);
    end
    total++;
    if ({bus_stb, bus_addr} !== {1'b1, 32'h108}) begin
      bad++; $display("FAIL tmo_next_accept: got stb=%b addr=%h want 1 00000108", bus_stb, bus_addr);
    end
    bus_ack = 1'b1; bus_rdata = 32'h55556666;
    @(negedge clk);
    total++;
    if ({if_ready, if_rdata} !== {1'b1, 32'h55556666}) begin
      bad++; $display("FAIL tmo_next_ready: got rdy=%b rdata=%h want 1 55556666", if_ready, if_rdata);
    end
    bus_ack = 1'b0; if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_flush();
    int seen_ready;
    seen_ready = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200;
    @(negedge clk);
    total++;
    if ({bus_stb, bus_addr} !== {1'b1, 32'h200}) begin
      bad++; $display("FAIL flush_stb: got stb=%b addr=%h want 1 00000200", bus_stb, bus_addr);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (bus_stb !== 1'b1) begin bad++; $display("FAIL flush_bus_kept: got stb=%b want 1", bus_stb); end
    bus_ack = 1'b1; bus_rdata = 32'hAAAABBBB; if_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      if (if_ready === 1'b1) seen_ready++;
    end
    total++;
    if (seen_ready != 0) begin bad++; $display("FAIL flush_no_ready: got %0d pulses want 0", seen_ready); end
    total++;
    if ({if_rdata, bus_stb} !== {32'h55556666, 1'b0}) begin
      bad++; $display("FAIL flush_rdata_kept: got rdata=%h stb=%b want 55556666 0", if_rdata, bus_stb);
    end
  endtask

  task automatic test_reset_mid_access();
    int seen_ready;
    seen_ready = 0;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_sel = 4'hC; mem_addr = 32'h4000; mem_wdata = 32'h12345678;
    @(negedge clk);
    total++;
    if (bus_stb !== 1'b1) begin bad++; $display("FAIL rstmid_stb: got %b want 1", bus_stb); end
    rst = 1'b1;
    #1;
    total++;
    if (stallreq_mem !== 1'b0) begin bad++; $display("FAIL rstmid_stall: got %b want 0", stallreq_mem); end
    @(negedge clk);
    total++;
    if ({bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, bus_wdata, if_ready, mem_ready,
         if_rdata, mem_rdata, bus_err, stallreq_mem} !== '0) begin
      bad++; $display("FAIL rstmid_outputs: got stb=%b we=%b sel=%h addr=%h rdata=%h/%h stall=%b want all zero",
                      bus_stb, bus_we, bus_sel, bus_addr, if_rdata, mem_rdata, stallreq_mem);
    end
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    bus_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1 || bus_stb === 1'b1) seen_ready++;
    end
    bus_ack = 1'b0;
    total++;
    if (seen_ready != 0) begin bad++; $display("FAIL rstmid_no_ready: got %0d active cycles want 0", seen_ready); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_store_wait();
    test_timeout();
    test_flush();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
